// File: rtl/hsk_sync_rx.sv
// Receiver for a 4-phase self-timed upstream: it synchronizes SENDIN, acks on FIFO space and queues DATAIN.
// Optional backpressure stall counter is enabled by defining HSK_SYNC_RX_STALL_CNT_EN.
module hsk_sync_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SENDIN,
  input  logic [DATA_W-1:0] DATAIN,
  output logic              ACKOUT,
  output logic              OUTVALID,
  input  logic              OUTREADY,
  output logic [DATA_W-1:0] DATAOUT,
  output logic [15:0]       STALLCNT
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACKD} st_t;

  st_t                          st;
  logic [SYNC_STAGES-1:0]       sync_pipe;
  logic                         req_s;
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [AW:0]                  wr_ptr, rd_ptr;
  logic                         full, push, pop;

  // SENDIN is asynchronous and only ever enters this chain.
  always_ff @(posedge CLK) begin
    if (RESET) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], SENDIN};
  end
  assign req_s = sync_pipe[SYNC_STAGES-1];

  // Extra pointer MSB tells full from empty when the index bits match.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign OUTVALID = (wr_ptr != rd_ptr);
  assign DATAOUT  = mem[rd_ptr[AW-1:0]];
  assign push     = (st == IDLE) && req_s && !full;
  assign pop      = OUTVALID && OUTREADY;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st     <= IDLE;
      ACKOUT <= 1'b0;
    end else begin
      case (st)
        IDLE: if (req_s && !full) begin
          st     <= ACKD;
          ACKOUT <= 1'b1;
        end
        ACKD: if (!req_s) begin
          st     <= IDLE;
          ACKOUT <= 1'b0;
        end
        default: begin
          st     <= IDLE;
          ACKOUT <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= DATAIN;
  end

`ifdef HSK_SYNC_RX_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge CLK) begin
    if (RESET)
      stall_q <= '0;
    else if ((st == IDLE) && req_s && full && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end
  assign STALLCNT = stall_q;
`else
  assign STALLCNT = '0;
`endif

endmodule

// File: tb/tb_hsk_sync_rx.sv
// Directed bench for hsk_sync_rx: latency, backpressure, release, wrap-around and mid-handshake reset.
module tb_hsk_sync_rx;
  logic        CLK = 1'b0;
  logic        RESET, SENDIN, OUTREADY, ACKOUT, OUTVALID;
  logic [7:0]  DATAIN, DATAOUT;
  logic [15:0] STALLCNT;
  int          nvec = 0, nerr = 0;
  logic [7:0]  rx [16];
  int          rcnt;

  always #5 CLK = ~CLK;

  hsk_sync_rx #(.DATA_W(8), .SYNC_STAGES(2), .DEPTH(2)) dut (
    .CLK(CLK), .RESET(RESET), .SENDIN(SENDIN), .DATAIN(DATAIN), .ACKOUT(ACKOUT),
    .OUTVALID(OUTVALID), .OUTREADY(OUTREADY), .DATAOUT(DATAOUT), .STALLCNT(STALLCNT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic wait_ack(input logic lvl);
    for (int i = 0; i < 64 && ACKOUT !== lvl; i++) step();
    chk(lvl ? "ack_rise" : "ack_fall", 32'(ACKOUT), 32'(lvl));
  endtask

  task automatic hs_send(input logic [7:0] d);
    DATAIN = d;
    SENDIN = 1'b1;
    wait_ack(1'b1);
    SENDIN = 1'b0;
    wait_ack(1'b0);
  endtask

  function automatic logic [31:0] stall_exp(input int k);
`ifdef HSK_SYNC_RX_STALL_CNT_EN
    return 32'(k);
`else
    return 32'(k * 0);
`endif
  endfunction

  initial begin
    RESET = 1'b1; SENDIN = 1'b0; DATAIN = '0; OUTREADY = 1'b0;
    repeat (3) step();
    chk("rst_ack",   32'(ACKOUT),   0);
    chk("rst_valid", 32'(OUTVALID), 0);
    chk("rst_stall", 32'(STALLCNT), 0);
    RESET = 1'b0;

    // single transfer: ack 3 edges after SENDIN rises, word visible after that same edge
    OUTREADY = 1'b1; DATAIN = 8'hA5; SENDIN = 1'b1;
    step(); chk("lat_e1", 32'(ACKOUT), 0);
    step(); chk("lat_e2", 32'(ACKOUT), 0);
    step(); chk("lat_e3", 32'(ACKOUT), 1);
    chk("st_valid", 32'(OUTVALID), 1);
    chk("st_data",  32'(DATAOUT),  32'h A5);
    step(); chk("st_popped", 32'(OUTVALID), 0);
    SENDIN = 1'b0;
    step(); chk("fall_e1", 32'(ACKOUT), 1);
    step(); chk("fall_e2", 32'(ACKOUT), 1);
    step(); chk("fall_e3", 32'(ACKOUT), 0);

    // backpressure: two words fill the FIFO, the third is held off
    OUTREADY = 1'b0;
    hs_send(8'h01);
    hs_send(8'h02);
    chk("bp_valid", 32'(OUTVALID), 1);
    chk("bp_head",  32'(DATAOUT),  32'h01);
    DATAIN = 8'h03; SENDIN = 1'b1;
    step(); step();
    chk("bp_stall0", 32'(STALLCNT), 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("bp_ack",   32'(ACKOUT),   0);
      chk("bp_stall", 32'(STALLCNT), stall_exp(k));
      chk("bp_hold",  32'(DATAOUT),  32'h01);
    end

    // release: full is sampled before the pop, so ack comes one edge later
    OUTREADY = 1'b1;
    step();
    chk("rel_ack0",  32'(ACKOUT),   0);
    chk("rel_d2",    32'(DATAOUT),  32'h02);
    chk("rel_stall", 32'(STALLCNT), stall_exp(7));
    step();
    chk("rel_ack1",  32'(ACKOUT),   1);
    chk("rel_d3",    32'(DATAOUT),  32'h03);
    chk("rel_v3",    32'(OUTVALID), 1);
    step();
    chk("rel_empty", 32'(OUTVALID), 0);
    SENDIN = 1'b0;
    wait_ack(1'b0);

    // wrap-around with a consumer toggling ready every cycle
    OUTREADY = 1'b0;
    rcnt = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) hs_send(8'(i));
      end
      begin
        for (int c = 0; c < 400; c++) begin
          @(negedge CLK);
          OUTREADY = ~OUTREADY;
          if (OUTVALID && OUTREADY) begin
            if (rcnt < 16) rx[rcnt] = DATAOUT;
            rcnt++;
          end
        end
      end
    join
    chk("wrap_cnt", 32'(rcnt), 10);
    for (int i = 0; i < 10; i++) chk("wrap_word", 32'(rx[i]), 32'(i));

    // reset while in ACKD with one queued word
    OUTREADY = 1'b0; DATAIN = 8'h55; SENDIN = 1'b1;
    wait_ack(1'b1);
    chk("mr_pre_valid", 32'(OUTVALID), 1);
    RESET = 1'b1;
    step();
    chk("mr_ack",   32'(ACKOUT),   0);
    chk("mr_valid", 32'(OUTVALID), 0);
    chk("mr_stall", 32'(STALLCNT), 0);
    RESET = 1'b0;
    step(); step();
    chk("mr_new_e2", 32'(ACKOUT), 0);
    step();
    chk("mr_new_ack",   32'(ACKOUT),   1);
    chk("mr_new_valid", 32'(OUTVALID), 1);
    chk("mr_new_data",  32'(DATAOUT),  32'h55);
    SENDIN = 1'b0;
    wait_ack(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
